// File: rtl/z80_fabric_bridge_pkg.sv
// Bridge-local types, plus the fabric architecture constants (carbon_arch_pkg) shared with fabric_if.
package z80_fabric_bridge_pkg;
   localparam int Z80_TMR_W = 16;

   typedef struct packed {
      logic        is_io;
      logic        write;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } z80_req_t;
endpackage

package carbon_arch_pkg;
   localparam int CARBON_FABRIC_OP_W   = 2;
   localparam int CARBON_FABRIC_SIZE_W = 3;
   localparam int CARBON_FABRIC_ID_W   = 4;
   localparam int CARBON_FABRIC_ATTR_W = 4;
   localparam int CARBON_FABRIC_CODE_W = 2;

   localparam logic [CARBON_FABRIC_OP_W-1:0]   CARBON_FABRIC_XACT_READ          = 2'd0;
   localparam logic [CARBON_FABRIC_OP_W-1:0]   CARBON_FABRIC_XACT_WRITE         = 2'd1;
   localparam logic [CARBON_FABRIC_ATTR_W-1:0] CARBON_FABRIC_ATTR_ORDERED_MASK  = 4'b0001;
   localparam logic [CARBON_FABRIC_ATTR_W-1:0] CARBON_FABRIC_ATTR_IO_SPACE_MASK = 4'b0010;
   localparam logic [CARBON_FABRIC_CODE_W-1:0] CARBON_FABRIC_RESP_OK            = 2'd0;
   localparam logic [CARBON_FABRIC_CODE_W-1:0] CARBON_FABRIC_RESP_SLVERR        = 2'd2;
   localparam logic [CARBON_FABRIC_CODE_W-1:0] CARBON_FABRIC_RESP_DECERR        = 2'd3;
endpackage

// File: rtl/z80_fabric_bridge_if.sv
// Fabric request/response port: master issues requests and accepts responses.
interface fabric_if
   import carbon_arch_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic                            req_valid;
   logic                            req_ready;
   logic [ADDR_W-1:0]               req_addr;
   logic [CARBON_FABRIC_OP_W-1:0]   req_op;
   logic [CARBON_FABRIC_SIZE_W-1:0] req_size;
   logic [CARBON_FABRIC_ID_W-1:0]   req_id;
   logic [CARBON_FABRIC_ATTR_W-1:0] req_attr;
   logic [DATA_W/8-1:0]             req_wstrb;
   logic [DATA_W-1:0]               req_wdata;
   logic                            rsp_valid;
   logic                            rsp_ready;
   logic [CARBON_FABRIC_ID_W-1:0]   rsp_id;
   logic [CARBON_FABRIC_CODE_W-1:0] rsp_code;
   logic [DATA_W-1:0]               rsp_rdata;

   modport master (
      output req_valid, req_addr, req_op, req_size, req_id, req_attr, req_wstrb, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_code, rsp_rdata
   );
   modport slave (
      input  req_valid, req_addr, req_op, req_size, req_id, req_attr, req_wstrb, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_code, rsp_rdata
   );
endinterface

// File: rtl/z80_fabric_bridge.sv
// Converts one Z80 memory/I/O cycle at a time into a single-byte fabric transaction.
// Define Z80_FABRIC_BRIDGE_TIMEOUT_EN to bound the response wait by TIMEOUT_CYCLES.
module z80_fabric_bridge
   import carbon_arch_pkg::*;
   import z80_fabric_bridge_pkg::*;
#(
   parameter int                    FAB_ADDR_W     = 32,
   parameter int                    FAB_DATA_W     = 32,
   parameter logic [FAB_ADDR_W-1:0] MEM_BASE       = FAB_ADDR_W'(32'h0000_0000),
   parameter logic [FAB_ADDR_W-1:0] IO_BASE        = FAB_ADDR_W'(32'h0001_0000),
   parameter int                    TXN_ID         = 0,
   parameter int                    TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_is_io,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_fault,
   fabric_if.master    fab
);
   localparam int NBYTES = FAB_DATA_W / 8;
   localparam int LANE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

   state_t            state;
   z80_req_t          cur;
   logic              fab_req_valid;
   logic              fab_rsp_ready;
   logic [LANE_W-1:0] lane;
   logic [7:0]        lane_byte;
   logic              rsp_hit;
`ifdef Z80_FABRIC_BRIDGE_TIMEOUT_EN
   logic [Z80_TMR_W-1:0] tmr_cnt;
`endif

   if (FAB_DATA_W < 8 || FAB_DATA_W > 64 || (FAB_DATA_W & (FAB_DATA_W - 1)) != 0) begin : g_bad_data_w
      $error("FAB_DATA_W must be a power of two in 8..64");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   // A one-byte fabric has no lane bits; lane 0 is then the only lane.
   assign lane      = (NBYTES > 1) ? cur.addr[LANE_W-1:0] : '0;
   assign lane_byte = fab.rsp_rdata[{lane, 3'b000} +: 8];
   assign rsp_hit   = fab.rsp_valid && fab_rsp_ready && (fab.rsp_id == CARBON_FABRIC_ID_W'(TXN_ID));

   assign fab.req_valid = fab_req_valid;
   assign fab.req_addr  = (cur.is_io ? IO_BASE : MEM_BASE) + FAB_ADDR_W'(cur.addr);
   assign fab.req_op    = cur.write ? CARBON_FABRIC_XACT_WRITE : CARBON_FABRIC_XACT_READ;
   assign fab.req_size  = '0;
   assign fab.req_id    = CARBON_FABRIC_ID_W'(TXN_ID);
   assign fab.req_attr  = CARBON_FABRIC_ATTR_ORDERED_MASK |
                          (cur.is_io ? CARBON_FABRIC_ATTR_IO_SPACE_MASK : '0);
   assign fab.req_wstrb = cur.write ? (NBYTES'(1) << lane) : '0;
   assign fab.req_wdata = {NBYTES{cur.wdata}};
   assign fab.rsp_ready = fab_rsp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cur           <= '0;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= 8'h00;
         rsp_fault     <= 1'b0;
         fab_req_valid <= 1'b0;
         fab_rsp_ready <= 1'b0;
`ifdef Z80_FABRIC_BRIDGE_TIMEOUT_EN
         tmr_cnt       <= '0;
`endif
      end else begin
         fab_rsp_ready <= 1'b1;
         rsp_valid     <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  cur           <= '{is_io: req_is_io, write: req_write, addr: req_addr, wdata: req_wdata};
                  req_ready     <= 1'b0;
                  fab_req_valid <= 1'b1;
                  state         <= ISSUE;
               end
            end
            // Responses seen here (even on the handshake cycle) are dropped.
            ISSUE: begin
               if (fab.req_ready) begin
                  fab_req_valid <= 1'b0;
                  state         <= WAIT_RSP;
`ifdef Z80_FABRIC_BRIDGE_TIMEOUT_EN
                  tmr_cnt       <= '0;
`endif
               end
            end
            WAIT_RSP: begin
               if (rsp_hit) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= cur.write ? 8'h00 : lane_byte;
                  rsp_fault <= (fab.rsp_code != CARBON_FABRIC_RESP_OK);
                  state     <= DONE;
               end
`ifdef Z80_FABRIC_BRIDGE_TIMEOUT_EN
               else if (tmr_cnt == Z80_TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= 8'hFF;
                  rsp_fault <= 1'b1;
                  state     <= DONE;
               end else begin
                  tmr_cnt <= tmr_cnt + Z80_TMR_W'(1);
               end
`endif
            end
            DONE: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_z80_fabric_bridge.sv
// Scoreboard bench for z80_fabric_bridge: directed Z80 cycles against a scripted fabric target.
module tb_z80_fabric_bridge;
   import carbon_arch_pkg::*;

   localparam int TO = 10;
   localparam logic [3:0] ORD = CARBON_FABRIC_ATTR_ORDERED_MASK;
   localparam logic [3:0] IOA = CARBON_FABRIC_ATTR_ORDERED_MASK | CARBON_FABRIC_ATTR_IO_SPACE_MASK;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_is_io = 1'b0, req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_fault;
   logic [7:0]  rsp_rdata;

   fabric_if #(.ADDR_W(32), .DATA_W(32)) fab ();

   z80_fabric_bridge #(
      .FAB_ADDR_W(32), .FAB_DATA_W(32), .MEM_BASE(32'h0000_0000), .IO_BASE(32'h0001_0000),
      .TXN_ID(0), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_io(req_is_io), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .fab(fab)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  op;
      logic [3:0]  attr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } fab_exp_t;
   typedef struct {
      logic [7:0] rdata;
      logic       fault;
      int         lat;
   } z80_exp_t;

   fab_exp_t fq[$];
   z80_exp_t zq[$];
   z80_exp_t z;
   int n_chk = 0, n_fail = 0, n_rsp = 0;
   int cyc = 0, acc_cyc = 0, gap_exp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_fab(input logic [31:0] a, input logic [1:0] op, input logic [3:0] attr,
                          input logic [3:0] strb, input logic [31:0] wd);
      fq.push_back('{addr: a, op: op, attr: attr, wstrb: strb, wdata: wd});
   endtask

   task automatic exp_z80(input logic [7:0] rd, input logic flt, input int lat);
      zq.push_back('{rdata: rd, fault: flt, lat: lat});
   endtask

   task automatic wait_ready();
      int n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) fail_now("wait_req_ready");
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1'b0);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
      chk({tag, "_rsp_fault"}, rsp_fault, 1'b0);
      chk({tag, "_fab_req_valid"}, fab.req_valid, 1'b0);
   endtask

   // Drive one Z80 cycle and play the fabric target; expectations are queued by the caller.
   task automatic run_txn(input logic io, input logic wr, input logic [15:0] a, input logic [7:0] d,
                          input int stall, input bit early, input bit bad_id,
                          input logic [1:0] code, input logic [31:0] frd, input bit respond);
      int n;
      req_is_io = io; req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
      fab.req_ready = (stall == 0);
      wait_ready();
      tick();
      req_valid = 1'b0;
      repeat (stall) tick();
      if (early) begin
         fab.rsp_valid = 1'b1; fab.rsp_id = '0;
         fab.rsp_code = CARBON_FABRIC_RESP_DECERR; fab.rsp_rdata = 32'hFFFF_FFFF;
      end
      fab.req_ready = 1'b1;
      tick();
      fab.req_ready = 1'b0;
      fab.rsp_valid = 1'b0;
      if (respond) begin
         if (bad_id) begin
            fab.rsp_valid = 1'b1; fab.rsp_id = 4'd3;
            fab.rsp_code = CARBON_FABRIC_RESP_OK; fab.rsp_rdata = 32'hFFFF_FFFF;
            tick();
         end
         fab.rsp_valid = 1'b1; fab.rsp_id = '0; fab.rsp_code = code; fab.rsp_rdata = frd;
         tick();
         fab.rsp_valid = 1'b0;
      end
      n = 0;
      while (zq.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) begin
         fail_now("wait_rsp_valid");
         zq.delete();
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (req_valid && req_ready) begin
            if (gap_exp != 0) chk("accept_gap", 64'(cyc - acc_cyc), 64'(gap_exp));
            acc_cyc = cyc;
         end
         if (fab.req_valid) begin
            chk("req_ready_while_issuing", req_ready, 1'b0);
            if (fq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_fab_req: got addr %0h, expected no request", fab.req_addr);
            end else begin
               chk("fab_req_addr", fab.req_addr, fq[0].addr);
               chk("fab_req_op", fab.req_op, fq[0].op);
               chk("fab_req_attr", fab.req_attr, fq[0].attr);
               chk("fab_req_wstrb", fab.req_wstrb, fq[0].wstrb);
               chk("fab_req_wdata", fab.req_wdata, fq[0].wdata);
               chk("fab_req_id", fab.req_id, 4'd0);
               chk("fab_req_size", fab.req_size, 3'd0);
               if (fab.req_ready) void'(fq.pop_front());
            end
         end
         if (rsp_valid) begin
            n_rsp++;
            if (zq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_rsp_valid: got rdata %0h fault %0b, expected no response",
                        rsp_rdata, rsp_fault);
            end else begin
               z = zq.pop_front();
               chk("rsp_rdata", rsp_rdata, z.rdata);
               chk("rsp_fault", rsp_fault, z.fault);
               if (z.lat >= 0) chk("rsp_latency", 64'(cyc - acc_cyc), 64'(z.lat));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      fab.req_ready = 1'b0; fab.rsp_valid = 1'b0; fab.rsp_id = '0;
      fab.rsp_code = CARBON_FABRIC_RESP_OK; fab.rsp_rdata = '0;
      rst = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();
      chk("rsp_ready_after_reset", fab.rsp_ready, 1'b1);
      chk("req_ready_after_reset", req_ready, 1'b1);

      // Memory read, lane 1, minimum latency.
      exp_fab(32'h0000_1235, CARBON_FABRIC_XACT_READ, ORD, 4'b0000, 32'h0);
      exp_z80(8'hCC, 1'b0, 3);
      run_txn(1'b0, 1'b0, 16'h1235, 8'h00, 0, 1'b0, 1'b0, CARBON_FABRIC_RESP_OK, 32'hAABB_CCDD, 1'b1);

      // I/O write issued back-to-back: next accept four cycles after the previous.
      gap_exp = 4;
      exp_fab(32'h0001_0042, CARBON_FABRIC_XACT_WRITE, IOA, 4'b0100, 32'h5A5A_5A5A);
      exp_z80(8'h00, 1'b0, 3);
      run_txn(1'b1, 1'b1, 16'h0042, 8'h5A, 0, 1'b0, 1'b0, CARBON_FABRIC_RESP_OK, 32'h1122_3344, 1'b1);
      gap_exp = 0;

      // Five-cycle stall with a response landing on the handshake cycle.
      exp_fab(32'h0000_FFFF, CARBON_FABRIC_XACT_READ, ORD, 4'b0000, 32'h0);
      exp_z80(8'h98, 1'b0, 8);
      run_txn(1'b0, 1'b0, 16'hFFFF, 8'h00, 5, 1'b1, 1'b0, CARBON_FABRIC_RESP_OK, 32'h9876_5432, 1'b1);

      // Foreign rsp_id ignored, completion on the matching one.
      exp_fab(32'h0001_0101, CARBON_FABRIC_XACT_READ, IOA, 4'b0000, 32'h0);
      exp_z80(8'h56, 1'b0, 4);
      run_txn(1'b1, 1'b0, 16'h0101, 8'h00, 0, 1'b0, 1'b1, CARBON_FABRIC_RESP_OK, 32'h1234_5678, 1'b1);

      // Error response still returns the lane byte, flagged as a fault.
      exp_fab(32'h0000_8003, CARBON_FABRIC_XACT_READ, ORD, 4'b0000, 32'h0);
      exp_z80(8'h55, 1'b1, 3);
      run_txn(1'b0, 1'b0, 16'h8003, 8'h00, 0, 1'b0, 1'b0, CARBON_FABRIC_RESP_SLVERR, 32'h5566_7788, 1'b1);

      // Reset while waiting for a response; the late response must vanish.
      exp_fab(32'h0000_0000, CARBON_FABRIC_XACT_READ, ORD, 4'b0000, 32'h0);
      req_is_io = 1'b0; req_write = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00;
      req_valid = 1'b1; fab.req_ready = 1'b1;
      wait_ready();
      tick();
      req_valid = 1'b0;
      tick();
      fab.req_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      tick();
      chk("req_ready_after_mid_reset", req_ready, 1'b1);
      fab.rsp_valid = 1'b1; fab.rsp_id = '0; fab.rsp_code = CARBON_FABRIC_RESP_OK;
      fab.rsp_rdata = 32'h0101_0101;
      tick();
      fab.rsp_valid = 1'b0;
      repeat (4) tick();
      chk("rsp_count_after_abandon", n_rsp, 5);

      // Normal operation resumes after the abandoned cycle.
      exp_fab(32'h0000_0002, CARBON_FABRIC_XACT_READ, ORD, 4'b0000, 32'h0);
      exp_z80(8'hAD, 1'b0, 3);
      run_txn(1'b0, 1'b0, 16'h0002, 8'h00, 0, 1'b0, 1'b0, CARBON_FABRIC_RESP_OK, 32'hDEAD_BEEF, 1'b1);

`ifdef Z80_FABRIC_BRIDGE_TIMEOUT_EN
      // No response: fault after TO cycles in WAIT_RSP, late response discarded.
      exp_fab(32'h0000_0010, CARBON_FABRIC_XACT_READ, ORD, 4'b0000, 32'h0);
      exp_z80(8'hFF, 1'b1, TO + 2);
      run_txn(1'b0, 1'b0, 16'h0010, 8'h00, 0, 1'b0, 1'b0, CARBON_FABRIC_RESP_OK, 32'h0, 1'b0);
      fab.rsp_valid = 1'b1; fab.rsp_id = '0; fab.rsp_code = CARBON_FABRIC_RESP_OK;
      fab.rsp_rdata = 32'h2222_2222;
      tick();
      fab.rsp_valid = 1'b0;
      repeat (4) tick();
      chk("rsp_count_after_timeout", n_rsp, 7);
`endif

      repeat (3) tick();
      chk("fab_queue_drained", fq.size(), 0);
      chk("rsp_queue_drained", zq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
